// File: rtl/alarm_bank_reg.sv
// rtl/alarm_bank_reg.sv - multi-slot BCD alarm register with per-minute match and latched hit
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_bank_reg #(
  parameter int NUM_ALARMS = 4,
  parameter int SLOT_W     = 2,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            new_alarm_ms_hr,
  input  logic [3:0]            new_alarm_ls_hr,
  input  logic [3:0]            new_alarm_ms_min,
  input  logic [3:0]            new_alarm_ls_min,
  input  logic                  load_new_alarm,
  input  logic [SLOT_W-1:0]     load_slot,
  input  logic                  clear_alarm,
  input  logic [SLOT_W-1:0]     rd_slot,
  input  logic [3:0]            current_time_ms_hr,
  input  logic [3:0]            current_time_ls_hr,
  input  logic [3:0]            current_time_ms_min,
  input  logic [3:0]            current_time_ls_min,
  input  logic                  minute_tick,
  input  logic                  stop_alarm,
  input  logic                  snooze,
  output logic [3:0]            alarm_time_ms_hr,
  output logic [3:0]            alarm_time_ls_hr,
  output logic [3:0]            alarm_time_ms_min,
  output logic [3:0]            alarm_time_ls_min,
  output logic [NUM_ALARMS-1:0] alarm_en_vec,
  output logic                  load_err,
  output logic                  alarm_hit,
  output logic [SLOT_W-1:0]     alarm_src
);

  logic [15:0]           r_digits [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_en;
  logic [15:0]           r_rd;
  logic                  r_load_err;
  logic                  r_hit;
  logic [SLOT_W-1:0]     r_src;

  logic [15:0]           w_new;
  logic [15:0]           w_cur;
  logic                  w_valid;
  logic                  w_slot_ok;
  logic                  w_rd_ok;
  logic                  w_err;
  logic                  w_any;
  logic [SLOT_W-1:0]     w_first;
  logic [15:0]           w_eff [NUM_ALARMS];

  assign w_new = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
  assign w_cur = {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};

  assign w_valid = (new_alarm_ms_hr <= 4'd2) && (new_alarm_ms_min <= 4'd5) &&
                   (new_alarm_ls_min <= 4'd9) &&
                   ((new_alarm_ms_hr == 4'd2) ? (new_alarm_ls_hr <= 4'd3) : (new_alarm_ls_hr <= 4'd9));

  assign w_slot_ok = int'(load_slot) < NUM_ALARMS;
  assign w_rd_ok   = int'(rd_slot) < NUM_ALARMS;
  // Clear beats load, so an invalid time paired with a clear is not an error.
  assign w_err = (load_new_alarm || clear_alarm) &&
                 (!w_slot_ok || (load_new_alarm && !clear_alarm && !w_valid));

`ifdef ALARM_SNOOZE_EN
  typedef enum logic {ARMED, SNOOZED} slot_state_t;

  slot_state_t r_state     [NUM_ALARMS];
  slot_state_t w_state_nxt [NUM_ALARMS];
  logic [15:0] r_target    [NUM_ALARMS];
  logic [15:0] w_snz_time;

  function automatic logic [15:0] add_minutes(input logic [15:0] t);
    int m;
    int h;
    m = int'(t[7:4]) * 10 + int'(t[3:0]) + SNOOZE_MIN;
    h = int'(t[15:12]) * 10 + int'(t[11:8]);
    if (m >= 60) begin
      m = m - 60;
      h = h + 1;
    end
    if (h >= 24) h = h - 24;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  assign w_snz_time = add_minutes(w_cur);

  always_comb begin
    w_state_nxt = r_state;
    if (stop_alarm) w_state_nxt[r_src] = ARMED;
    else if (snooze && r_hit) w_state_nxt[r_src] = SNOOZED;
    if (w_slot_ok && (clear_alarm || (load_new_alarm && w_valid))) w_state_nxt[load_slot] = ARMED;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_state[i]  <= ARMED;
        r_target[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (snooze && r_hit && !stop_alarm) r_target[r_src] <= w_snz_time;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++)
      w_eff[i] = (r_state[i] == SNOOZED) ? r_target[i] : r_digits[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) w_eff[i] = r_digits[i];
  end
`endif

  // Descending scan leaves the lowest matching index in w_first.
  always_comb begin
    w_any   = 1'b0;
    w_first = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_en[i] && (w_eff[i] == w_cur)) begin
        w_any   = 1'b1;
        w_first = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) r_digits[i] <= '0;
      r_en       <= '0;
      r_rd       <= '0;
      r_load_err <= 1'b0;
      r_hit      <= 1'b0;
      r_src      <= '0;
    end else begin
      r_load_err <= w_err;
      if (w_slot_ok && clear_alarm) begin
        r_en[load_slot] <= 1'b0;
      end else if (w_slot_ok && load_new_alarm && w_valid) begin
        r_digits[load_slot] <= w_new;
        r_en[load_slot]     <= 1'b1;
      end
      r_rd <= w_rd_ok ? r_digits[rd_slot] : 16'h0000;
      if (stop_alarm) begin
        r_hit <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      end else if (snooze && r_hit) begin
        r_hit <= 1'b0;
`endif
      end else if (!r_hit && minute_tick && w_any) begin
        r_hit <= 1'b1;
        r_src <= w_first;
      end
    end
  end

  assign {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = r_rd;
  assign alarm_en_vec = r_en;
  assign load_err     = r_load_err;
  assign alarm_hit    = r_hit;
  assign alarm_src    = r_src;

endmodule

// File: tb/tb_alarm_bank_reg.sv
// tb/tb_alarm_bank_reg.sv - directed self-checking bench for alarm_bank_reg
// Snooze vectors run only when ALARM_SNOOZE_EN is defined.
module tb_alarm_bank_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
  logic       load_new_alarm;
  logic [1:0] load_slot;
  logic       clear_alarm;
  logic [1:0] rd_slot;
  logic [3:0] current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min;
  logic       minute_tick;
  logic       stop_alarm;
  logic       snooze;
  logic [3:0] alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
  logic [3:0] alarm_en_vec;
  logic       load_err;
  logic       alarm_hit;
  logic [1:0] alarm_src;

  int n_total = 0;
  int n_bad   = 0;

  alarm_bank_reg #(.NUM_ALARMS(4), .SLOT_W(2), .SNOOZE_MIN(5)) dut (
    .clock(clock), .reset(reset),
    .new_alarm_ms_hr(new_alarm_ms_hr), .new_alarm_ls_hr(new_alarm_ls_hr),
    .new_alarm_ms_min(new_alarm_ms_min), .new_alarm_ls_min(new_alarm_ls_min),
    .load_new_alarm(load_new_alarm), .load_slot(load_slot), .clear_alarm(clear_alarm),
    .rd_slot(rd_slot),
    .current_time_ms_hr(current_time_ms_hr), .current_time_ls_hr(current_time_ls_hr),
    .current_time_ms_min(current_time_ms_min), .current_time_ls_min(current_time_ls_min),
    .minute_tick(minute_tick), .stop_alarm(stop_alarm), .snooze(snooze),
    .alarm_time_ms_hr(alarm_time_ms_hr), .alarm_time_ls_hr(alarm_time_ls_hr),
    .alarm_time_ms_min(alarm_time_ms_min), .alarm_time_ls_min(alarm_time_ls_min),
    .alarm_en_vec(alarm_en_vec), .load_err(load_err), .alarm_hit(alarm_hit), .alarm_src(alarm_src)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rd_time();
    return {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min};
  endfunction

  task automatic set_cur(input logic [15:0] t);
    {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min} = t;
  endtask

  task automatic load(input logic [1:0] slot, input logic [15:0] t);
    {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min} = t;
    load_slot      = slot;
    load_new_alarm = 1'b1;
    step();
    load_new_alarm = 1'b0;
  endtask

  task automatic clear(input logic [1:0] slot);
    load_slot   = slot;
    clear_alarm = 1'b1;
    step();
    clear_alarm = 1'b0;
  endtask

  task automatic tick(input logic [15:0] t);
    set_cur(t);
    minute_tick = 1'b1;
    step();
    minute_tick = 1'b0;
  endtask

  task automatic stop();
    stop_alarm = 1'b1;
    step();
    stop_alarm = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min} = 16'h0;
    load_new_alarm = 0; load_slot = 0; clear_alarm = 0; rd_slot = 0;
    set_cur(16'h0000);
    minute_tick = 0; stop_alarm = 0; snooze = 0;
    repeat (5) step();
    check("rst_hit", alarm_hit, 0);
    check("rst_en", alarm_en_vec, 0);
    check("rst_time", rd_time(), 0);
    check("rst_err", load_err, 0);
    check("rst_src", alarm_src, 0);
    reset = 1'b0;
    step();

    rd_slot = 2;
    load(2, 16'h0730);
    check("ld_err0", load_err, 0);
    check("ld_en", alarm_en_vec, 4'b0100);
    step();
    check("ld_rd", rd_time(), 16'h0730);

    load(1, 16'h2400);
    check("bad24_err", load_err, 1);
    step();
    check("bad24_pulse", load_err, 0);
    load(1, 16'h1A00);
    check("bad1A_err", load_err, 1);
    step();
    check("bad1A_pulse", load_err, 0);
    check("bad_en", alarm_en_vec, 4'b0100);
    rd_slot = 1;
    step(); step();
    check("bad_rd", rd_time(), 16'h0000);

    load(0, 16'h0615);
    load(3, 16'h0615);
    check("en_03", alarm_en_vec, 4'b1101);
    tick(16'h0616);
    check("nomatch", alarm_hit, 0);
    tick(16'h0615);
    check("hit_lo", alarm_hit, 1);
    check("src_lo", alarm_src, 0);
    stop();
    check("stop", alarm_hit, 0);

    stop_alarm = 1'b1;
    tick(16'h0615);
    stop_alarm = 1'b0;
    check("stop_vs_match", alarm_hit, 0);

    load(1, 16'h1200);
    check("en1_set", alarm_en_vec, 4'b1111);
    clear(1);
    check("en1_clr", alarm_en_vec, 4'b1101);
    tick(16'h1200);
    check("clr_nohit", alarm_hit, 0);
    step();
    check("clr_keep", rd_time(), 16'h1200);
    {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min} = 16'h1100;
    load_slot = 1; load_new_alarm = 1; clear_alarm = 1;
    step();
    load_new_alarm = 0; clear_alarm = 0;
    check("ldclr_en", alarm_en_vec, 4'b1101);
    check("ldclr_err", load_err, 0);

    tick(16'h0730);
    check("hit2", alarm_hit, 1);
    check("src2", alarm_src, 2);
    tick(16'h0615);
    check("no_resrc", alarm_src, 2);
    load(2, 16'h0800);
    check("ld_firing", alarm_hit, 1);
    clear(2);
    check("clr_firing", alarm_hit, 1);
    stop();
    check("stop2", alarm_hit, 0);
    load(2, 16'h0730);

`ifdef ALARM_SNOOZE_EN
    load(0, 16'h2358);
    tick(16'h2358);
    check("snz_fire", alarm_hit, 1);
    check("snz_src", alarm_src, 0);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("snz_clr", alarm_hit, 0);
    tick(16'h0002);
    check("snz_early", alarm_hit, 0);
    tick(16'h0003);
    check("snz_hit", alarm_hit, 1);
    check("snz_src2", alarm_src, 0);
    stop();
    check("snz_stop", alarm_hit, 0);
    load(0, 16'h0615);
`endif

    rd_slot = 2;
    tick(16'h0730);
    check("pre_rst_hit", alarm_hit, 1);
    check("pre_rst_rd", rd_time(), 16'h0730);
    reset = 1'b1;
    #1;
    check("arst_hit", alarm_hit, 0);
    check("arst_en", alarm_en_vec, 0);
    check("arst_rd", rd_time(), 0);
    check("arst_src", alarm_src, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
